// File: rtl/cnn1d_pkg.sv
// Shared types for the CNN condition voter.
package cnn1d_pkg;

   // Voter control states: collect a window, scan for the winner, hold the verdict.
   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DECIDE = 2'd1,
      REPORT = 2'd2
   } vote_state_t;

endpackage

// File: rtl/cnn1d_condition_voter.sv
// Tumbling-window majority voter with confidence threshold and hysteresis.
// Accepts per-window class results from the CNN, scans class counters one
// per cycle for the winner, and holds a registered verdict for downstream.
module cnn1d_condition_voter
   import cnn1d_pkg::*;
#(
   parameter int NUM_CLASSES   = 2,
   parameter int CLASS_WIDTH   = 1,
   parameter int WINDOW        = 8,
   parameter int THRESHOLD     = 6,
   parameter int DEFAULT_CLASS = 0,
   parameter int ERR_WIDTH     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   vote_valid_in,
   output logic                   vote_ready_in,
   input  logic [CLASS_WIDTH-1:0] vote_class_in,
   output logic                   vote_valid_out,
   input  logic                   vote_ready_out,
   output logic [CLASS_WIDTH-1:0] vote_class_out,
   output logic                   vote_changed_out,
   output logic                   vote_confident_out,
   output logic [ERR_WIDTH-1:0]   err_count
);

   localparam int CNT_W = $clog2(WINDOW + 1);
   localparam logic [CNT_W-1:0]       WIN_LAST = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0]       THR      = CNT_W'(THRESHOLD);
   localparam logic [CLASS_WIDTH:0]   NUM_CLS  = (CLASS_WIDTH + 1)'(NUM_CLASSES);
   localparam logic [CLASS_WIDTH-1:0] LAST_CLS = CLASS_WIDTH'(NUM_CLASSES - 1);
   localparam logic [CLASS_WIDTH-1:0] DEF_CLS  = CLASS_WIDTH'(DEFAULT_CLASS);

   vote_state_t            state, state_nxt;
   logic [CNT_W-1:0]       cls_cnt [NUM_CLASSES];
   logic [CNT_W-1:0]       win_cnt;
   logic [CLASS_WIDTH-1:0] scan_idx;
   logic [CNT_W-1:0]       best_cnt;
   logic [CLASS_WIDTH-1:0] best_idx;

   logic                   take;
   logic                   in_range;
   logic                   win_done;
   logic                   scan_last;
   logic [CNT_W-1:0]       scan_cnt;
   logic [CNT_W-1:0]       best_cnt_nxt;
   logic [CLASS_WIDTH-1:0] best_idx_nxt;
   logic                   final_conf;

   // Handshake flags come straight from the registered state, so there is no
   // combinational path from vote_ready_out back to vote_ready_in.
   assign vote_ready_in  = (state == ACCUM);
   assign vote_valid_out = (state == REPORT);
   assign take           = vote_valid_in & vote_ready_in;
   assign in_range       = ({1'b0, vote_class_in} < NUM_CLS);
   assign win_done       = (win_cnt == WIN_LAST);
   assign scan_last      = (scan_idx == LAST_CLS);

   // Argmax step: strict greater-than keeps the lower index on ties.
   always_comb begin
      scan_cnt     = cls_cnt[scan_idx];
      best_cnt_nxt = best_cnt;
      best_idx_nxt = best_idx;
      if (scan_cnt > best_cnt) begin
         best_cnt_nxt = scan_cnt;
         best_idx_nxt = scan_idx;
      end
      final_conf = (best_cnt_nxt >= THR);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (take && win_done) state_nxt = DECIDE;
         DECIDE:  if (scan_last)        state_nxt = REPORT;
         REPORT:  if (vote_ready_out)   state_nxt = ACCUM;
         default:                       state_nxt = ACCUM;
      endcase
   end

   // Counters, argmax scan and registered verdict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CLASSES; i++) cls_cnt[i] <= '0;
         win_cnt            <= '0;
         scan_idx           <= '0;
         best_cnt           <= '0;
         best_idx           <= '0;
         err_count          <= '0;
         vote_class_out     <= DEF_CLS;
         vote_changed_out   <= 1'b0;
         vote_confident_out <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (take) begin
                  win_cnt <= win_cnt + 1'b1;
                  if (in_range)
                     cls_cnt[vote_class_in] <= cls_cnt[vote_class_in] + 1'b1;
                  else if (err_count != '1)
                     err_count <= err_count + 1'b1;
                  // Arm the scan for the window that just closed.
                  if (win_done) begin
                     scan_idx <= '0;
                     best_cnt <= '0;
                     best_idx <= '0;
                  end
               end
            end
            DECIDE: begin
               scan_idx <= scan_idx + 1'b1;
               best_cnt <= best_cnt_nxt;
               best_idx <= best_idx_nxt;
               if (scan_last) begin
                  // Below threshold the old verdict is held (hysteresis).
                  vote_confident_out <= final_conf;
                  vote_changed_out   <= final_conf && (best_idx_nxt != vote_class_out);
                  if (final_conf) vote_class_out <= best_idx_nxt;
               end
            end
            REPORT: begin
               if (vote_ready_out) begin
                  for (int i = 0; i < NUM_CLASSES; i++) cls_cnt[i] <= '0;
                  win_cnt            <= '0;
                  vote_changed_out   <= 1'b0;
                  vote_confident_out <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn1d_condition_voter.sv
// Scoreboard bench for the condition voter: two instances (2-class/TH=6 and
// 3-class/TH=4 with out-of-range codes), randomized windows and backpressure.
module tb_cnn1d_condition_voter;

   localparam int WIN = 8;
   localparam int NC [2] = '{2, 3};
   localparam int TH [2] = '{6, 4};

   typedef struct {
      int cls;
      int chg;
      int conf;
      int err;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid_in  [2];
   logic [1:0] cls_in    [2];
   logic       ready_out [2];

   logic       a_ready_in, a_valid_out, a_changed, a_conf;
   logic [0:0] a_cls_out;
   logic [7:0] a_err;
   logic       b_ready_in, b_valid_out, b_changed, b_conf;
   logic [1:0] b_cls_out;
   logic [7:0] b_err;

   logic       ready_in  [2];
   logic       valid_out [2];
   logic       changed   [2];
   logic       conf      [2];
   logic [1:0] cls_out   [2];
   logic [7:0] err       [2];

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   rdy_mode [2];     // 0: always ready, 1: held low, 2: random
   exp_t exp_q [2][$];

   int   m_cnt [2][4];
   int   m_n   [2];
   int   m_verdict [2];
   int   m_err [2];

   cnn1d_condition_voter #(
      .NUM_CLASSES(2), .CLASS_WIDTH(1), .WINDOW(WIN), .THRESHOLD(6),
      .DEFAULT_CLASS(0), .ERR_WIDTH(8)
   ) dut_a (
      .clk(clk), .rst(rst),
      .vote_valid_in(valid_in[0]), .vote_ready_in(a_ready_in),
      .vote_class_in(cls_in[0][0:0]),
      .vote_valid_out(a_valid_out), .vote_ready_out(ready_out[0]),
      .vote_class_out(a_cls_out), .vote_changed_out(a_changed),
      .vote_confident_out(a_conf), .err_count(a_err)
   );

   cnn1d_condition_voter #(
      .NUM_CLASSES(3), .CLASS_WIDTH(2), .WINDOW(WIN), .THRESHOLD(4),
      .DEFAULT_CLASS(0), .ERR_WIDTH(8)
   ) dut_b (
      .clk(clk), .rst(rst),
      .vote_valid_in(valid_in[1]), .vote_ready_in(b_ready_in),
      .vote_class_in(cls_in[1]),
      .vote_valid_out(b_valid_out), .vote_ready_out(ready_out[1]),
      .vote_class_out(b_cls_out), .vote_changed_out(b_changed),
      .vote_confident_out(b_conf), .err_count(b_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      ready_in[0] = a_ready_in;  ready_in[1] = b_ready_in;
      valid_out[0] = a_valid_out; valid_out[1] = b_valid_out;
      changed[0] = a_changed;    changed[1] = b_changed;
      conf[0] = a_conf;          conf[1] = b_conf;
      cls_out[0] = {1'b0, a_cls_out}; cls_out[1] = b_cls_out;
      err[0] = a_err;            err[1] = b_err;
   end

   task automatic chk(input string name, input int d, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s dut%0d actual %0d expected %0d (t=%0t)", name, d, act, expv, $time);
      end
   endtask

   task automatic model_reset(input int d);
      for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
      m_n[d] = 0;
      m_verdict[d] = 0;
      m_err[d] = 0;
      exp_q[d].delete();
   endtask

   // Reference: majority over the window, lowest class wins ties, threshold
   // gates the update, out-of-range codes only fill the window.
   task automatic model_xfer(input int d, input int c, input int t);
      int   mx;
      int   win;
      exp_t e;
      m_n[d]++;
      if (c < NC[d]) m_cnt[d][c]++;
      else if (m_err[d] < 255) m_err[d]++;
      if (m_n[d] == WIN) begin
         mx = 0;
         for (int k = 0; k < NC[d]; k++) if (m_cnt[d][k] > mx) mx = m_cnt[d][k];
         win = 0;
         for (int k = NC[d] - 1; k >= 0; k--) if (m_cnt[d][k] == mx) win = k;
         e.conf = (mx >= TH[d]) ? 1 : 0;
         e.chg  = (e.conf == 1 && win != m_verdict[d]) ? 1 : 0;
         if (e.conf == 1) m_verdict[d] = win;
         e.cls = m_verdict[d];
         e.err = m_err[d];
         e.cyc = t + 1 + NC[d];
         exp_q[d].push_back(e);
         for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
         m_n[d] = 0;
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send(input int d, input int c);
      int waited = 0;
      valid_in[d] = 1'b1;
      cls_in[d]   = 2'(c);
      while (!ready_in[d]) begin
         if (waited >= 200) begin
            chk("send_timeout", d, 1, 0);
            valid_in[d] = 1'b0;
            return;
         end
         @(negedge clk);
         waited++;
      end
      model_xfer(d, c, cyc);
      @(negedge clk);
      valid_in[d] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_reset_state(input int d);
      chk("rst_ready_in", d, ready_in[d], 1);
      chk("rst_valid_out", d, valid_out[d], 0);
      chk("rst_class_out", d, cls_out[d], 0);
      chk("rst_err_count", d, err[d], 0);
   endtask

   task automatic rand_window(input int d);
      int dom;
      int c;
      dom = int'($urandom % NC[d]);
      for (int i = 0; i < WIN; i++) begin
         if ($urandom % 8 < 5) c = dom;
         else c = (d == 0) ? int'($urandom % 2) : int'($urandom % 4);
         repeat ($urandom % 3) @(negedge clk);
         send(d, c);
      end
   endtask

   task automatic drain(input int d);
      int w = 0;
      while ((exp_q[d].size() != 0 || valid_out[d]) && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", d, exp_q[d].size(), 0);
   endtask

   // Downstream ready driver.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++)
         ready_out[d] = (rdy_mode[d] == 0) ? 1'b1 :
                        (rdy_mode[d] == 1) ? 1'b0 : 1'($urandom % 2);
   end

   // Monitor: pops an expectation on each rising verdict, then checks that the
   // verdict holds still and inputs stay blocked until the handshake.
   logic prev_v   [2];
   logic after_hs [2];
   exp_t snap     [2];
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            prev_v[d]   = 1'b0;
            after_hs[d] = 1'b0;
         end else begin
            if (after_hs[d]) begin
               chk("ready_again", d, ready_in[d], 1);
               chk("valid_dropped", d, valid_out[d], 0);
            end
            if (valid_out[d]) begin
               if (!prev_v[d]) begin
                  if (exp_q[d].size() == 0) begin
                     chk("spurious_verdict", d, 1, 0);
                  end else begin
                     e = exp_q[d].pop_front();
                     chk("class_out", d, cls_out[d], e.cls);
                     chk("changed", d, changed[d], e.chg);
                     chk("confident", d, conf[d], e.conf);
                     chk("err_count", d, err[d], e.err);
                     chk("latency_cycle", d, cyc, e.cyc);
                  end
                  snap[d].cls  = cls_out[d];
                  snap[d].chg  = changed[d];
                  snap[d].conf = conf[d];
                  snap[d].err  = err[d];
               end else begin
                  chk("hold_class", d, cls_out[d], snap[d].cls);
                  chk("hold_changed", d, changed[d], snap[d].chg);
                  chk("hold_conf", d, conf[d], snap[d].conf);
                  chk("hold_err", d, err[d], snap[d].err);
               end
               chk("ready_in_blocked", d, ready_in[d], 0);
            end
            after_hs[d] = valid_out[d] & ready_out[d];
            prev_v[d]   = valid_out[d];
         end
      end
   end

   initial begin
      int w;
      for (int d = 0; d < 2; d++) begin
         valid_in[d] = 1'b0;
         cls_in[d]   = 2'd0;
         rdy_mode[d] = 0;
         ready_out[d] = 1'b1;
         prev_v[d] = 1'b0;
         after_hs[d] = 1'b0;
      end
      model_reset(0);
      model_reset(1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_state(0);
      check_reset_state(1);

      // Partial window thrown away by a reset.
      for (int i = 0; i < 3; i++) send(0, 1);
      do_reset();
      check_reset_state(0);
      for (int i = 0; i < WIN; i++) send(0, 1);          // -> 1, changed
      drain(0);
      chk("class_kept_after_hs", 0, cls_out[0], 1);

      // Hysteresis hold: 5x0 + 3x1 below threshold.
      for (int i = 0; i < 5; i++) send(0, 0);
      for (int i = 0; i < 3; i++) send(0, 1);
      drain(0);
      for (int i = 0; i < WIN; i++) send(0, 1);          // confident, unchanged
      drain(0);

      // Backpressure: verdict held 10 cycles with upstream pushing.
      rdy_mode[0] = 1;
      for (int i = 0; i < WIN; i++) send(0, 0);
      w = 0;
      while (!valid_out[0] && w < 50) begin @(negedge clk); w++; end
      chk("bp_verdict_seen", 0, valid_out[0], 1);
      valid_in[0] = 1'b1;
      cls_in[0] = 2'd1;
      repeat (10) @(negedge clk);
      valid_in[0] = 1'b0;
      rdy_mode[0] = 0;
      drain(0);

      // Random windows with random downstream readiness.
      rdy_mode[0] = 2;
      for (int k = 0; k < 12; k++) rand_window(0);
      rdy_mode[0] = 0;
      drain(0);

      // Three-class instance: tie resolves low, then out-of-range codes.
      for (int i = 0; i < 4; i++) send(1, 0);
      for (int i = 0; i < 4; i++) send(1, 1);
      drain(1);
      for (int i = 0; i < 6; i++) send(1, 2);
      for (int i = 0; i < 2; i++) send(1, 3);
      drain(1);
      rdy_mode[1] = 2;
      for (int k = 0; k < 12; k++) rand_window(1);
      rdy_mode[1] = 0;
      drain(1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cnn1d_condition_voter.md
Name: cnn1d_condition_voter

Overview:
Consumer-side counterpart of the sample feeder. It sits on the output of m10_cnn1d and accepts per-window classification results (cnn_condition) through a ready/valid handshake. It aggregates results over a tumbling window, takes a majority vote with a confidence threshold and hysteresis, and presents a stable machine-condition verdict downstream through its own ready/valid handshake.

Parameters:
- NUM_CLASSES, 2, number of valid class indices (0..NUM_CLASSES-1); 2 = healthy/worn.
- CLASS_WIDTH, 1, width of the class index bus; must satisfy 2**CLASS_WIDTH >= NUM_CLASSES.
- WINDOW, 8, number of accepted results per vote.
- THRESHOLD, 6, minimum winning count needed to update the verdict; 1 <= THRESHOLD <= WINDOW.
- DEFAULT_CLASS, 0, verdict after reset.
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- vote_valid_in, in, 1, upstream result valid.
- vote_ready_in, out, 1, block can accept a result.
- vote_class_in, in, CLASS_WIDTH, upstream class index (cnn_condition).
- vote_valid_out, out, 1, verdict available.
- vote_ready_out, in, 1, downstream accepts the verdict.
- vote_class_out, out, CLASS_WIDTH, current verdict.
- vote_changed_out, out, 1, verdict differs from the previous verdict.
- vote_confident_out, out, 1, winning count >= THRESHOLD.
- err_count, out, ERR_WIDTH, count of out-of-range class inputs; saturating.

Behaviour:
- Reset (async, rst=1):
  - State ACCUM; all class counters and the window counter cleared.
  - vote_ready_in=1 after reset release.
  - vote_valid_out=0, vote_class_out=DEFAULT_CLASS, vote_changed_out=0, vote_confident_out=0, err_count=0.
- Input transfer happens on a clk edge where vote_valid_in & vote_ready_in. vote_ready_in = (state==ACCUM), registered-state based with no combinational path from vote_ready_out.
- ACCUM:
  - Each transfer increments the window counter.
  - If the class is < NUM_CLASSES, increment that class counter.
  - Otherwise, count toward the window only and increment err_count, saturating at all-ones.
  - The transfer that makes the window counter reach WINDOW moves the state to DECIDE on the same edge.
- DECIDE:
  - Scans one class per cycle (index 0 to NUM_CLASSES-1), tracking the best count and its index.
  - Only a strictly greater count replaces the best, so ties resolve to the lower index.
  - After the last class, the next edge enters REPORT.
  - Latency: vote_valid_out rises exactly NUM_CLASSES cycles after the window-completing transfer edge.
- Entering REPORT:
  - confident = best_count >= THRESHOLD.
  - If confident, the new verdict is the best index; otherwise the previous verdict is held (hysteresis).
  - changed = confident & (best index != previous verdict).
  - vote_class_out, vote_changed_out and vote_confident_out are registered and stable while vote_valid_out=1.
- REPORT:
  - vote_valid_out=1 and vote_ready_in=0.
  - On vote_valid_out & vote_ready_out: clear class and window counters, vote_valid_out=0, return to ACCUM (ready again next cycle).
  - vote_class_out keeps the verdict after the handshake. vote_changed_out and vote_confident_out are meaningful only while vote_valid_out=1.
- Counter width: class and window counters are $clog2(WINDOW+1) bits; no overflow is possible because inputs are blocked outside ACCUM.
- Backpressure: vote_ready_out may stay low indefinitely. Outputs must not change and no input may be accepted meanwhile.
- Reset mid-window or mid-REPORT: returns immediately to the reset values. Partial window counts are discarded.
- vote_valid_in may toggle freely; only transfer edges count.

Decomposition:
- cnn1d_pkg gets vote_state_t (ACCUM, DECIDE, REPORT) as an enum.
- No sub-module: the argmax scan is a small counter inside this module.

Test Plan (WINDOW=8, THRESHOLD=6, NUM_CLASSES=2):
1. Reset with inputs idle -> vote_ready_in=1, vote_valid_out=0, vote_class_out=0, err_count=0; assert rst mid-window (3 accepted) then send 8× class 1 -> one verdict, class 1.
2. 8 back-to-back class 1 results, vote_ready_out=1 -> vote_valid_out high 2 cycles after the 8th transfer edge for 1 cycle; class_out=1, changed=1, confident=1; vote_ready_in high again on the following cycle.
3. From verdict 1, send 5× class 0 + 3× class 1 -> class_out=1, changed=0, confident=0 (hysteresis hold).
4. Tie 4× class 0 / 4× class 1 with THRESHOLD=4 -> class_out=0, confident=1.
5. Hold vote_ready_out=0 for 10 cycles in REPORT while vote_valid_in=1 -> vote_ready_in=0, no counts change, outputs stable; one verdict transfer when released.
6. NUM_CLASSES=3, CLASS_WIDTH=2: window of 6× class 2 + 2× class 3 -> err_count=2, class_out=2, confident=1.
